tug_match_ctrl: RTL and testbench

//  Match sequencer for the two-player tug game. Owns the shared 3-bit position tracker.
//  - Arbitrates the left/right player press strobes into single-cycle move grants.
//  - Clears the tracker at each round start.
//  - Awards a point when the marker is held at an end position; keeps score and declares the match winner.

---
 rtl/tug_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 64 ++++++
 rtl/tug_match_ctrl.sv | 137 +++++++++++++
 tb/tb_tug_match_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tug_pkg.sv
// Shared codes for the tug match sequencer: FSM states, tracker positions, winner encoding.
package tug_pkg;

  localparam logic [2:0] ST_IDLE  = 3'b000;
  localparam logic [2:0] ST_ARM   = 3'b001;
  localparam logic [2:0] ST_PLAY  = 3'b010;
  localparam logic [2:0] ST_POINT = 3'b011;
  localparam logic [2:0] ST_OVER  = 3'b100;

  localparam logic [2:0] POS_C   = 3'b000;
  localparam logic [2:0] POS_L1  = 3'b001;
  localparam logic [2:0] POS_L2  = 3'b010;
  localparam logic [2:0] POS_L3  = 3'b011;
  localparam logic [2:0] POS_R1  = 3'b100;
  localparam logic [2:0] POS_R2  = 3'b101;
  localparam logic [2:0] POS_R3  = 3'b110;
  localparam logic [2:0] POS_INV = 3'b111;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b01;
  localparam logic [1:0] WIN_RIGHT = 2'b10;

  // True when the marker sits on either scoring end (L3 or R3).
  function automatic logic pos_is_end(input logic [2:0] p);
    return (p == POS_L3) || (p == POS_R3);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-player press arbiter: 1-deep pending flag per player, round-robin on contention,
// registered single-cycle grants. Disabled (flags cleared, no grants) outside play.
module rr_arb2
  import tug_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_l,
  input  logic req_r,
  output logic gnt_l,
  output logic gnt_r
);

  logic pend_l_q, pend_l_d;
  logic pend_r_q, pend_r_d;
  logic rr_r_q, rr_r_d;        // 0: left has priority on next contention, 1: right
  logic gnt_l_q, gnt_l_d;
  logic gnt_r_q, gnt_r_d;
  logic eff_l, eff_r;

  // A fresh press competes in the cycle it arrives; losers wait in their pending flag.
  always_comb begin
    eff_l    = pend_l_q | req_l;
    eff_r    = pend_r_q | req_r;
    gnt_l_d  = 1'b0;
    gnt_r_d  = 1'b0;
    rr_r_d   = rr_r_q;
    if (en) begin
      if (eff_l && eff_r) begin
        gnt_l_d = !rr_r_q;
        gnt_r_d = rr_r_q;
        rr_r_d  = !rr_r_q;
      end else begin
        gnt_l_d = eff_l;
        gnt_r_d = eff_r;
      end
    end
    // A flag survives a grant only if a new press for that player lands in the same cycle.
    pend_l_d = en & ((pend_l_q & req_l) | (eff_l & ~gnt_l_d));
    pend_r_d = en & ((pend_r_q & req_r) | (eff_r & ~gnt_r_d));
  end

  // Arbiter state and registered grants.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      rr_r_q   <= 1'b0;
      gnt_l_q  <= 1'b0;
      gnt_r_q  <= 1'b0;
    end else begin
      pend_l_q <= pend_l_d;
      pend_r_q <= pend_r_d;
      rr_r_q   <= rr_r_d;
      gnt_l_q  <= gnt_l_d;
      gnt_r_q  <= gnt_r_d;
    end
  end

  assign gnt_l = gnt_l_q;
  assign gnt_r = gnt_r_q;

endmodule

// File: rtl/tug_match_ctrl.sv
// Tug match sequencer: round FSM, shared arm/round timer, end-hold counter, scores and winner.
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int SCORE_W   = 4,
  parameter int WIN_SCORE = 5,
  parameter int HOLD_CYC  = 3,
  parameter int ARM_CYC   = 4,
  parameter int ROUND_CYC = 64,
  parameter int TMR_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               l_press,
  input  logic               r_press,
  input  logic [2:0]         pos,
  output logic               move_l,
  output logic               move_r,
  output logic               track_clr,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [1:0]         winner,
  output logic               danger,
  output logic [2:0]         ctrl_state
);

  logic [2:0]         state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [TMR_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0] score_l_q, score_l_d;
  logic [SCORE_W-1:0] score_r_q, score_r_d;
  logic [1:0]         winner_q, winner_d;
  logic               track_clr_q, track_clr_d;
  logic               danger_q, danger_d;
  logic               in_play, at_end, hold_hit, round_over;

  // Scores stop at all-ones rather than wrapping.
  function automatic logic [SCORE_W-1:0] inc_sat(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign in_play    = (state_q == ST_PLAY);
  assign at_end     = pos_is_end(pos);
  assign hold_hit   = in_play && at_end && (hold_q == TMR_W'(HOLD_CYC - 1));
  assign round_over = (tmr_q == TMR_W'(ROUND_CYC - 1));

  // Next-state, scoring and strobe decode; a point beats a same-cycle round timeout.
  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    winner_d  = winner_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d   = ST_ARM;
          score_l_d = '0;
          score_r_d = '0;
          winner_d  = WIN_NONE;
        end
      end
      ST_ARM: begin
        if (tmr_q == TMR_W'(ARM_CYC - 1)) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (hold_hit) begin
          state_d = ST_POINT;
          if (pos == POS_L3) score_l_d = inc_sat(score_l_q);
          else               score_r_d = inc_sat(score_r_q);
        end else if (round_over) begin
          state_d = ST_ARM;
        end
      end
      ST_POINT: begin
        if (score_l_q >= SCORE_W'(WIN_SCORE)) begin
          state_d  = ST_OVER;
          winner_d = WIN_LEFT;
        end else if (score_r_q >= SCORE_W'(WIN_SCORE)) begin
          state_d  = ST_OVER;
          winner_d = WIN_RIGHT;
        end else begin
          state_d  = ST_ARM;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The one timer restarts at 0 on every state change and only runs in ARM and PLAY.
    tmr_d = ((state_d == state_q) && ((state_q == ST_ARM) || in_play)) ? tmr_q + 1'b1 : '0;
    // Consecutive cycles at an end; any other position (including 111) restarts the count.
    hold_d      = (in_play && at_end) ? hold_q + 1'b1 : '0;
    track_clr_d = (state_d == ST_ARM) && (state_q != ST_ARM);
    danger_d    = in_play && at_end;
  end

  // Match state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      hold_q      <= '0;
      score_l_q   <= '0;
      score_r_q   <= '0;
      winner_q    <= WIN_NONE;
      track_clr_q <= 1'b0;
      danger_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      hold_q      <= hold_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      winner_q    <= winner_d;
      track_clr_q <= track_clr_d;
      danger_q    <= danger_d;
    end
  end

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (in_play),
    .req_l (l_press),
    .req_r (r_press),
    .gnt_l (move_l),
    .gnt_r (move_r)
  );

  assign track_clr  = track_clr_q;
  assign score_l    = score_l_q;
  assign score_r    = score_r_q;
  assign winner     = winner_q;
  assign danger     = danger_q;
  assign ctrl_state = state_q;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Scoreboard bench for tug_match_ctrl: stimulus queues expected output events, a monitor
// pops one whenever a strobe fires, the state changes, or the stimulus requests a probe.
module tb_tug_match_ctrl;
  import tug_pkg::*;

  typedef struct packed {
    logic [2:0] st;
    logic       ml;
    logic       mr;
    logic       tc;
    logic [3:0] sl;
    logic [3:0] sr;
    logic [1:0] w;
    logic       dg;
  } ev_t;

  logic       clk, rst_n, start, l_press, r_press, probe, stim_done;
  logic [2:0] pos;
  logic       move_l, move_r, track_clr, danger;
  logic [3:0] score_l, score_r;
  logic [1:0] winner;
  logic [2:0] ctrl_state;

  ev_t   exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  tug_match_ctrl dut (
    .clk        (clk),
    .reset      (rst_n),
    .start      (start),
    .l_press    (l_press),
    .r_press    (r_press),
    .pos        (pos),
    .move_l     (move_l),
    .move_r     (move_r),
    .track_clr  (track_clr),
    .score_l    (score_l),
    .score_r    (score_r),
    .winner     (winner),
    .danger     (danger),
    .ctrl_state (ctrl_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout, want summary");
    $fatal(1, "watchdog");
  end

  function automatic string fmt(input ev_t e);
    return $sformatf("st=%0d ml=%0d mr=%0d tc=%0d sl=%0d sr=%0d w=%0d dg=%0d",
                     e.st, e.ml, e.mr, e.tc, e.sl, e.sr, e.w, e.dg);
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    ev_t        obs, e;
    string      tg;
    logic [2:0] prev_st;
    prev_st = ST_IDLE;
    forever begin
      @(negedge clk);
      n_cmp++;
      if (move_l === 1'b1 && move_r === 1'b1) begin
        n_err++;
        $display("FAIL grant_mutex: got move_l=1 move_r=1, want at most one");
      end
      obs = {ctrl_state, move_l, move_r, track_clr, score_l, score_r, winner, danger};
      if (probe || move_l || move_r || track_clr || (ctrl_state != prev_st)) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_event: got %s, want no event", fmt(obs));
        end else begin
          e  = exp_q.pop_front();
          tg = tag_q.pop_front();
          if (obs !== e) begin
            n_err++;
            $display("FAIL %s: got %s, want %s", tg, fmt(obs), fmt(e));
          end
        end
      end
      prev_st = ctrl_state;
      if (stim_done) begin
        n_cmp++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL missing_events: got %0d left unseen (next %s), want 0",
                   exp_q.size(), tag_q[0]);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic expect_ev(input string tag, input logic [2:0] st, input logic ml,
                           input logic mr, input logic tc, input logic [3:0] sl,
                           input logic [3:0] sr, input logic [1:0] w, input logic dg);
    ev_t e;
    e = {st, ml, mr, tc, sl, sr, w, dg};
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Next edge causes entry to ARM (optionally by start); returns just after PLAY is entered.
  task automatic arm_cycle(input logic with_start, input logic [3:0] sl, input logic [3:0] sr);
    expect_ev("arm_entry", ST_ARM, 1'b0, 1'b0, 1'b1, sl, sr, WIN_NONE, 1'b0);
    expect_ev("play_entry", ST_PLAY, 1'b0, 1'b0, 1'b0, sl, sr, WIN_NONE, 1'b0);
    start = with_start;
    tick();
    start = 1'b0;
    repeat (4) tick();
    probe = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; l_press = 1'b0; r_press = 1'b0;
    pos = POS_C; probe = 1'b0; stim_done = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    expect_ev("reset_state", ST_IDLE, 0, 0, 0, 4'd0, 4'd0, WIN_NONE, 0);
    probe = 1'b1;

    // Match start, three left presses, then a left-end hold for a point.
    arm_cycle(1'b1, 4'd0, 4'd0);
    repeat (3) begin
      expect_ev("press_l", ST_PLAY, 1, 0, 0, 4'd0, 4'd0, WIN_NONE, 0);
      l_press = 1'b1; tick(); l_press = 1'b0; tick();
    end
    pos = POS_L3;
    repeat (3) tick();
    expect_ev("point_l", ST_POINT, 0, 0, 0, 4'd1, 4'd0, WIN_NONE, 1);
    probe = 1'b1; pos = POS_C;
    arm_cycle(1'b0, 4'd1, 4'd0);

    // Simultaneous presses: rr flips; then a re-press during a grant stays pending.
    expect_ev("both1_l", ST_PLAY, 1, 0, 0, 4'd1, 4'd0, WIN_NONE, 0);
    expect_ev("both1_r", ST_PLAY, 0, 1, 0, 4'd1, 4'd0, WIN_NONE, 0);
    l_press = 1'b1; r_press = 1'b1; tick(); l_press = 1'b0; r_press = 1'b0; tick(); tick();
    expect_ev("both2_r", ST_PLAY, 0, 1, 0, 4'd1, 4'd0, WIN_NONE, 0);
    expect_ev("both2_l", ST_PLAY, 1, 0, 0, 4'd1, 4'd0, WIN_NONE, 0);
    l_press = 1'b1; r_press = 1'b1; tick(); l_press = 1'b0; r_press = 1'b0; tick(); tick();
    expect_ev("both3_l", ST_PLAY, 1, 0, 0, 4'd1, 4'd0, WIN_NONE, 0);
    expect_ev("repress_r1", ST_PLAY, 0, 1, 0, 4'd1, 4'd0, WIN_NONE, 0);
    expect_ev("repress_r2", ST_PLAY, 0, 1, 0, 4'd1, 4'd0, WIN_NONE, 0);
    l_press = 1'b1; r_press = 1'b1; tick(); l_press = 1'b0; tick(); r_press = 1'b0; tick(); tick();

    // Right-end hold broken by R1: point only on the third consecutive R3 cycle.
    pos = POS_R3; tick(); tick();
    expect_ev("hold2_no_point", ST_PLAY, 0, 0, 0, 4'd1, 4'd0, WIN_NONE, 1);
    probe = 1'b1; pos = POS_R1; tick();
    expect_ev("hold_broken", ST_PLAY, 0, 0, 0, 4'd1, 4'd0, WIN_NONE, 0);
    probe = 1'b1; pos = POS_R3; tick(); tick(); tick();
    expect_ev("point_r", ST_POINT, 0, 0, 0, 4'd1, 4'd1, WIN_NONE, 1);
    probe = 1'b1; pos = POS_C;
    arm_cycle(1'b0, 4'd1, 4'd1);

    // Idle round times out after 64 play cycles with scores unchanged.
    repeat (63) tick();
    expect_ev("play_cycle64", ST_PLAY, 0, 0, 0, 4'd1, 4'd1, WIN_NONE, 0);
    probe = 1'b1;
    arm_cycle(1'b0, 4'd1, 4'd1);

    // Hold completes on the timeout cycle: the point takes precedence.
    repeat (61) tick();
    pos = POS_L3; tick(); tick(); tick();
    expect_ev("point_at_timeout", ST_POINT, 0, 0, 0, 4'd2, 4'd1, WIN_NONE, 1);
    probe = 1'b1; pos = POS_C;
    arm_cycle(1'b0, 4'd2, 4'd1);

    // Asynchronous reset mid-play.
    tick();
    expect_ev("reset_mid_play", ST_IDLE, 0, 0, 0, 4'd0, 4'd0, WIN_NONE, 0);
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    expect_ev("after_reset", ST_IDLE, 0, 0, 0, 4'd0, 4'd0, WIN_NONE, 0);
    probe = 1'b1;
    arm_cycle(1'b1, 4'd0, 4'd0);

    // Right wins five points, match ends, presses ignored, rematch clears.
    for (int k = 1; k <= 5; k++) begin
      pos = POS_R3; tick(); tick(); tick();
      expect_ev("point_r_run", ST_POINT, 0, 0, 0, 4'd0, 4'(k), WIN_NONE, 1);
      probe = 1'b1; pos = POS_C;
      if (k < 5) arm_cycle(1'b0, 4'd0, 4'(k));
    end
    expect_ev("over_entry", ST_OVER, 0, 0, 0, 4'd0, 4'd5, WIN_RIGHT, 0);
    tick();
    l_press = 1'b1; tick(); l_press = 1'b0; tick(); tick();
    expect_ev("over_held", ST_OVER, 0, 0, 0, 4'd0, 4'd5, WIN_RIGHT, 0);
    probe = 1'b1; tick();
    arm_cycle(1'b1, 4'd0, 4'd0);

    // start ignored in PLAY; pos 111 breaks a hold.
    start = 1'b1; tick(); start = 1'b0;
    expect_ev("start_in_play", ST_PLAY, 0, 0, 0, 4'd0, 4'd0, WIN_NONE, 0);
    probe = 1'b1;
    pos = POS_L3; tick(); tick();
    pos = POS_INV; tick();
    pos = POS_L3; tick(); tick();
    expect_ev("invalid_breaks_hold", ST_PLAY, 0, 0, 0, 4'd0, 4'd0, WIN_NONE, 1);
    probe = 1'b1; pos = POS_C;
    tick(); tick(); tick();
    stim_done = 1'b1;
  end

endmodule
